// File: rtl/multi_mode_storage_bank.sv
// Multi-lane storage bank: per-lane edge capture, transparent, delay-line or frozen
// behaviour selected by a registered run-time mode. Entirely flop based.
module multi_mode_storage_bank #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        clr,
  input  logic [CHANNELS-1:0]         en,
  input  logic [CHANNELS*WIDTH-1:0]   d,
  output logic [CHANNELS*WIDTH-1:0]   q,
  output logic [CHANNELS-1:0]         valid
);

  localparam logic [1:0] MODE_FLOP  = 2'b00;
  localparam logic [1:0] MODE_TRANS = 2'b01;
  localparam logic [1:0] MODE_DELAY = 2'b10;
  localparam logic [1:0] MODE_HOLD  = 2'b11;

  localparam int             FW        = $clog2(DEPTH + 1);
  localparam logic [FW-1:0]  FILL_FULL = FW'(DEPTH);

  logic [CHANNELS-1:0][DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CHANNELS-1:0][FW-1:0]               fill_q, fill_d;
  logic [CHANNELS-1:0]                       cap_q, cap_d;
  logic [1:0]                                mode_q;
  logic                                      mode_change;

  assign mode_change = (mode != mode_q);

  // Storage follows the old mode; a mode change then wipes fill/captured but keeps data.
  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    cap_d   = cap_q;
    for (int c = 0; c < CHANNELS; c++) begin
      if (clr) begin
        stage_d[c] = '0;
        fill_d[c]  = '0;
        cap_d[c]   = 1'b0;
      end else begin
        if (en[c]) begin
          case (mode_q)
            MODE_FLOP, MODE_TRANS: begin
              stage_d[c][0] = d[c*WIDTH +: WIDTH];
              cap_d[c]      = 1'b1;
            end
            MODE_DELAY: begin
              for (int k = 1; k < DEPTH; k++) begin
                stage_d[c][k] = stage_q[c][k-1];
              end
              stage_d[c][0] = d[c*WIDTH +: WIDTH];
              if (fill_q[c] != FILL_FULL) begin
                fill_d[c] = fill_q[c] + FW'(1);
              end
            end
            default: begin
            end
          endcase
        end
        if (mode_change) begin
          fill_d[c] = '0;
          cap_d[c]  = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      fill_q  <= '0;
      cap_q   <= '0;
      mode_q  <= MODE_FLOP;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      cap_q   <= cap_d;
      mode_q  <= mode;
    end
  end

  always_comb begin
    q     = '0;
    valid = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      case (mode_q)
        MODE_FLOP: begin
          q[c*WIDTH +: WIDTH] = stage_q[c][0];
          valid[c]            = cap_q[c];
        end
        MODE_TRANS: begin
          q[c*WIDTH +: WIDTH] = en[c] ? d[c*WIDTH +: WIDTH] : stage_q[c][0];
          valid[c]            = en[c] | cap_q[c];
        end
        MODE_DELAY: begin
          q[c*WIDTH +: WIDTH] = stage_q[c][DEPTH-1];
          valid[c]            = (fill_q[c] == FILL_FULL);
        end
        default: begin
          q[c*WIDTH +: WIDTH] = stage_q[c][0];
          valid[c]            = cap_q[c] | (fill_q[c] == FILL_FULL);
        end
      endcase
    end
  end

endmodule
